// File: rtl/bit_population_counter_pipe.sv
// -----------------------------------------------------------------------------
// bit_population_counter_pipe
//
// Purpose:
//   Pipelined population counter. The WIDTH-bit input word is zero-padded to a
//   power of two and reduced by a binary adder tree; a pipeline register sits
//   after every LVL_PER_STAGE tree levels. A valid/ready handshake with
//   bubble-collapsing backpressure moves words through the stages. A
//   saturating running total accumulates every popcount that leaves the block.
//
// Ports:
//   clk_i         in   clock, rising edge
//   rst_i         in   asynchronous active-high reset
//   data_i        in   word to count
//   data_valid_i  in   data_i valid
//   data_ready_o  out  block accepts data_i this cycle (combinational)
//   data_o        out  popcount of one accepted word
//   data_valid_o  out  data_o valid
//   data_ready_i  in   downstream accepts data_o
//   clr_i         in   synchronous clear of total_o (clear first, then add)
//   total_o       out  saturating sum of all transferred data_o values
// -----------------------------------------------------------------------------
module bit_population_counter_pipe #(
    parameter int unsigned WIDTH         = 16,
    parameter int unsigned LVL_PER_STAGE = 2,
    parameter int unsigned TOTAL_W       = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     data_valid_i,
    output logic                     data_ready_o,
    output logic [$clog2(WIDTH):0]   data_o,
    output logic                     data_valid_o,
    input  logic                     data_ready_i,
    input  logic                     clr_i,
    output logic [TOTAL_W-1:0]       total_o
);

    // Tree geometry: D levels over P = 2^D leaves, S pipeline stages.
    localparam int unsigned D  = $clog2(WIDTH);
    localparam int unsigned OW = D + 1;
    localparam int unsigned P  = 1 << D;
    localparam int unsigned S  = (D == 0) ? 1 : (D + LVL_PER_STAGE - 1) / LVL_PER_STAGE;

    // Every stage carries P slots of OW bits. Slots beyond the live sum count
    // are forced to zero, and the upper bits of narrow sums stay zero, so the
    // unused storage is constant.
    typedef logic [P-1:0][OW-1:0] sum_arr_t;

    // Number of tree levels completed at the output of stage k (stage 0 = input).
    function automatic int unsigned lvl_after(int unsigned k);
        int unsigned l;
        l = k * LVL_PER_STAGE;
        return (l > D) ? D : l;
    endfunction

    // Apply tree levels from_lvl .. to_lvl-1 to an array of partial sums.
    // The pairwise reduction is done in place: slot i reads slots 2i and 2i+1,
    // which are never overwritten before they are read.
    function automatic sum_arr_t reduce_levels(sum_arr_t in_arr, int unsigned from_lvl,
                                               int unsigned to_lvl);
        sum_arr_t    cur;
        int unsigned cnt;
        cur = in_arr;
        for (int unsigned l = 0; l < D; l++) begin
            if (l >= from_lvl && l < to_lvl) begin
                cnt = P >> (l + 1);
                for (int unsigned i = 0; i < P / 2; i++) begin
                    if (i < cnt) begin
                        cur[i] = cur[2*i] + cur[2*i+1];
                    end
                end
                for (int unsigned i = 0; i < P; i++) begin
                    if (i >= cnt) begin
                        cur[i] = '0;
                    end
                end
            end
        end
        return cur;
    endfunction

    sum_arr_t         w_pad_arr;
    sum_arr_t [S:0]   w_src;
    sum_arr_t [S-1:0] w_next;
    sum_arr_t [S-1:0] r_sum;
    logic     [S-1:0] r_valid;
    logic     [S-1:0] w_adv;
    logic     [S:0]   w_vsrc;

    logic               w_xfer;
    logic [TOTAL_W-1:0] w_total_base;
    logic [TOTAL_W:0]   w_total_sum;
    logic [TOTAL_W-1:0] r_total;
    logic               w_unused_bits;

    // Leaves: one bit per slot, pad slots stay zero so they never count.
    always_comb begin
        w_pad_arr = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            w_pad_arr[i][0] = data_i[i];
        end
    end

    // Source of stage k is stage k-1; index 0 is the padded input word.
    assign w_src  = {r_sum, w_pad_arr};
    assign w_vsrc = {r_valid, data_valid_i};

    always_comb begin
        for (int unsigned k = 0; k < S; k++) begin
            w_next[k] = reduce_levels(w_src[k], lvl_after(k), lvl_after(k + 1));
        end
    end

    // Bubble collapsing: a stage may load whenever it is empty or the stage
    // after it is moving, so ready ripples back combinationally.
    always_comb begin
        w_adv        = '0;
        w_adv[S-1]   = ~r_valid[S-1] | data_ready_i;
        for (int k = int'(S) - 2; k >= 0; k--) begin
            w_adv[k] = ~r_valid[k] | w_adv[k+1];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_valid <= '0;
            r_sum   <= '0;
        end else begin
            for (int unsigned k = 0; k < S; k++) begin
                if (w_adv[k]) begin
                    r_valid[k] <= w_vsrc[k];
                    // Data only moves with a valid word; bubbles leave it untouched.
                    if (w_vsrc[k]) begin
                        r_sum[k] <= w_next[k];
                    end
                end
            end
        end
    end

    assign data_ready_o = w_adv[0];
    assign data_valid_o = r_valid[S-1];
    assign data_o       = r_sum[S-1][0];

    // Running total: clear takes effect before the add of a same-cycle transfer.
    assign w_xfer       = data_valid_o & data_ready_i;
    assign w_total_base = clr_i ? '0 : r_total;
    assign w_total_sum  = {1'b0, w_total_base} + (TOTAL_W + 1)'(data_o);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_total <= '0;
        end else if (w_xfer) begin
            r_total <= w_total_sum[TOTAL_W] ? '1 : w_total_sum[TOTAL_W-1:0];
        end else if (clr_i) begin
            r_total <= '0;
        end
    end

    assign total_o = r_total;

    // Last-stage slice of the source vectors is not consumed by the tree.
    assign w_unused_bits = ^{w_src[S], w_vsrc[S]};

endmodule

// File: tb/tb_bit_population_counter_pipe.sv
// -----------------------------------------------------------------------------
// tb_bit_population_counter_pipe
//
// Purpose:
//   Directed self-checking bench. Four instances: defaults (d_*), TOTAL_W = 5
//   (s_*), WIDTH = 13 / LVL_PER_STAGE = 1 (x_*), WIDTH = 1 / LVL_PER_STAGE = 1
//   (y_*). Inputs change 1 time unit after a rising edge; outputs are sampled
//   between edges.
// -----------------------------------------------------------------------------
module tb_bit_population_counter_pipe;

    logic clk;
    logic rst;

    logic [15:0] d_data;
    logic        d_valid, d_rdy_o, d_vout, d_rdy_i, d_clr;
    logic [4:0]  d_out;
    logic [31:0] d_total;

    logic [15:0] s_data;
    logic        s_valid, s_rdy_o, s_vout, s_rdy_i, s_clr;
    logic [4:0]  s_out;
    logic [4:0]  s_total;

    logic [12:0] x_data;
    logic        x_valid, x_rdy_o, x_vout, x_rdy_i, x_clr;
    logic [4:0]  x_out;
    logic [31:0] x_total;

    logic [0:0]  y_data;
    logic        y_valid, y_rdy_o, y_vout, y_rdy_i, y_clr;
    logic [0:0]  y_out;
    logic [31:0] y_total;

    int checks;
    int errors;

    bit_population_counter_pipe u_dut (
        .clk_i(clk), .rst_i(rst), .data_i(d_data), .data_valid_i(d_valid),
        .data_ready_o(d_rdy_o), .data_o(d_out), .data_valid_o(d_vout),
        .data_ready_i(d_rdy_i), .clr_i(d_clr), .total_o(d_total)
    );

    bit_population_counter_pipe #(.WIDTH(16), .LVL_PER_STAGE(2), .TOTAL_W(5)) u_sat (
        .clk_i(clk), .rst_i(rst), .data_i(s_data), .data_valid_i(s_valid),
        .data_ready_o(s_rdy_o), .data_o(s_out), .data_valid_o(s_vout),
        .data_ready_i(s_rdy_i), .clr_i(s_clr), .total_o(s_total)
    );

    bit_population_counter_pipe #(.WIDTH(13), .LVL_PER_STAGE(1), .TOTAL_W(32)) u_w13 (
        .clk_i(clk), .rst_i(rst), .data_i(x_data), .data_valid_i(x_valid),
        .data_ready_o(x_rdy_o), .data_o(x_out), .data_valid_o(x_vout),
        .data_ready_i(x_rdy_i), .clr_i(x_clr), .total_o(x_total)
    );

    bit_population_counter_pipe #(.WIDTH(1), .LVL_PER_STAGE(1), .TOTAL_W(32)) u_w1 (
        .clk_i(clk), .rst_i(rst), .data_i(y_data), .data_valid_i(y_valid),
        .data_ready_o(y_rdy_o), .data_o(y_out), .data_valid_o(y_vout),
        .data_ready_i(y_rdy_i), .clr_i(y_clr), .total_o(y_total)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Hand-computed popcounts.
    logic [15:0] t1_in  [4] = '{16'hFFFF, 16'h0000, 16'hA5A5, 16'h0001};
    int          t1_exp [4] = '{16, 0, 8, 1};
    logic [12:0] x_words [8] = '{13'h1FFF, 13'h0000, 13'h1555, 13'h0ABC,
                                 13'h1001, 13'h0800, 13'h1000, 13'h0F0F};
    int          x_exp  [8] = '{13, 0, 7, 7, 2, 1, 1, 8};
    logic        y_words [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    int          y_exp  [8] = '{1, 0, 1, 1, 0, 1, 0, 1};
    logic [15:0] rpat = 16'b1011_0011_1101_0110;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int x_in, x_idx, y_in, y_idx;
        checks = 0;
        errors = 0;
        rst = 1'b0;
        d_data = '0; d_valid = 1'b0; d_rdy_i = 1'b1; d_clr = 1'b0;
        s_data = '0; s_valid = 1'b0; s_rdy_i = 1'b1; s_clr = 1'b0;
        x_data = '0; x_valid = 1'b0; x_rdy_i = 1'b1; x_clr = 1'b0;
        y_data = '0; y_valid = 1'b0; y_rdy_i = 1'b1; y_clr = 1'b0;

        // Reset state
        #1 rst = 1'b1;
        #2;
        chk("rst_vout", d_vout, 0);
        chk("rst_out", d_out, 0);
        chk("rst_total", d_total, 0);
        tick();
        tick();
        rst = 1'b0;
        #1 chk("rst_ready", d_rdy_o, 1);

        // Back-to-back stream, no stall
        d_rdy_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d_data  = t1_in[i];
            d_valid = 1'b1;
            #1 chk("t1_ready", d_rdy_o, 1);
            tick();
            if (i >= 1) begin
                chk("t1_out", d_out, t1_exp[i-1]);
                chk("t1_vout", d_vout, 1);
            end
        end
        d_valid = 1'b0;
        tick();
        chk("t1_out_last", d_out, t1_exp[3]);
        chk("t1_total_mid", d_total, 24);
        tick();
        chk("t1_vout_empty", d_vout, 0);
        chk("t1_total", d_total, 25);

        // Full stall then release
        d_rdy_i = 1'b0;
        d_data  = 16'h00FF;
        d_valid = 1'b1;
        #1 chk("t2_ready_a", d_rdy_o, 1);
        tick();
        d_data = 16'h0F0F;
        #1 chk("t2_ready_b", d_rdy_o, 1);
        tick();
        d_data = 16'h0003;
        #1 chk("t2_ready_full", d_rdy_o, 0);
        chk("t2_out_stall", d_out, 8);
        chk("t2_vout_stall", d_vout, 1);
        tick();
        chk("t2_out_hold", d_out, 8);
        chk("t2_ready_hold", d_rdy_o, 0);
        d_rdy_i = 1'b1;
        #1 chk("t2_ready_release", d_rdy_o, 1);
        tick();
        d_valid = 1'b0;
        chk("t2_out_2nd", d_out, 8);
        tick();
        chk("t2_out_3rd", d_out, 2);
        tick();
        chk("t2_vout_empty", d_vout, 0);
        chk("t2_total", d_total, 43);

        // Single word after a gap, bubble collapse while stalled
        d_rdy_i = 1'b0;
        d_valid = 1'b0;
        repeat (3) tick();
        chk("t3_vout_idle", d_vout, 0);
        d_data  = 16'h8001;
        d_valid = 1'b1;
        #1 chk("t3_ready_a", d_rdy_o, 1);
        tick();
        d_valid = 1'b0;
        #1 chk("t3_ready_b", d_rdy_o, 1);
        chk("t3_vout_s1", d_vout, 0);
        tick();
        chk("t3_vout_s2", d_vout, 1);
        chk("t3_out_s2", d_out, 2);
        chk("t3_ready_c", d_rdy_o, 1);
        tick();
        chk("t3_out_hold", d_out, 2);
        d_rdy_i = 1'b1;
        tick();
        chk("t3_total", d_total, 45);
        chk("t3_vout_empty", d_vout, 0);

        // Saturating total with TOTAL_W = 5, then clear during a transfer
        s_rdy_i = 1'b1;
        s_data  = 16'hFFFF;
        s_valid = 1'b1;
        tick();
        tick();
        tick();
        s_valid = 1'b0;
        chk("t4_total_16", s_total, 16);
        tick();
        chk("t4_total_sat", s_total, 31);
        tick();
        chk("t4_total_sat2", s_total, 31);
        s_data  = 16'h0007;
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        tick();
        chk("t4_out_7", s_out, 3);
        s_clr = 1'b1;
        tick();
        s_clr = 1'b0;
        chk("t4_clr_xfer", s_total, 3);
        s_clr = 1'b1;
        tick();
        s_clr = 1'b0;
        chk("t4_clr_only", s_total, 0);

        // Asynchronous reset mid-stream
        d_rdy_i = 1'b1;
        d_data  = 16'h000F;
        d_valid = 1'b1;
        tick();
        d_data = 16'h00F0;
        tick();
        d_valid = 1'b0;
        chk("t5_inflight_vout", d_vout, 1);
        chk("t5_inflight_out", d_out, 4);
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_vout", d_vout, 0);
        chk("t5_rst_out", d_out, 0);
        chk("t5_rst_total", d_total, 0);
        tick();
        #2 rst = 1'b0;
        #1 chk("t5_ready", d_rdy_o, 1);
        d_data  = 16'h0101;
        d_valid = 1'b1;
        tick();
        d_valid = 1'b0;
        chk("t5_vout_s1", d_vout, 0);
        tick();
        chk("t5_vout", d_vout, 1);
        chk("t5_out", d_out, 2);

        // WIDTH = 13 latency
        x_rdy_i = 1'b1;
        x_data  = 13'h1FFF;
        x_valid = 1'b1;
        lat = 0;
        tick();
        lat++;
        x_valid = 1'b0;
        while (!x_vout && lat < 20) begin
            tick();
            lat++;
        end
        chk("t6_w13_latency", lat, 4);
        chk("t6_w13_out_allones", x_out, 13);
        tick();
        chk("t6_w13_drained", x_vout, 0);

        // WIDTH = 1 latency
        y_rdy_i = 1'b1;
        y_data  = 1'b1;
        y_valid = 1'b1;
        lat = 0;
        tick();
        lat++;
        y_valid = 1'b0;
        while (!y_vout && lat < 20) begin
            tick();
            lat++;
        end
        chk("t6_w1_latency", lat, 1);
        chk("t6_w1_out", y_out, 1);
        tick();
        chk("t6_w1_drained", y_vout, 0);

        // Streams with irregular downstream ready
        x_in = 0; x_idx = 0; y_in = 0; y_idx = 0;
        for (int c = 0; c < 100 && (x_idx < 8 || y_idx < 8); c++) begin
            x_valid = (x_in < 8);
            x_data  = (x_in < 8) ? x_words[x_in] : 13'h0;
            x_rdy_i = rpat[c % 16];
            y_valid = (y_in < 8);
            y_data  = (y_in < 8) ? y_words[y_in] : 1'b0;
            y_rdy_i = rpat[(c + 5) % 16];
            #1;
            if (x_vout && x_rdy_i) begin
                chk("t6_w13_stream", x_out, x_exp[x_idx]);
                x_idx++;
            end
            if (y_vout && y_rdy_i) begin
                chk("t6_w1_stream", y_out, y_exp[y_idx]);
                y_idx++;
            end
            if (x_valid && x_rdy_o) x_in++;
            if (y_valid && y_rdy_o) y_in++;
            tick();
        end
        chk("t6_w13_count", x_idx, 8);
        chk("t6_w1_count", y_idx, 8);
        chk("t6_w13_total", x_total, 52);
        chk("t6_w1_total", y_total, 6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
